// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, sample type and bit-reversal helper.
package fft_pkg;

    localparam int N     = 64;
    localparam int LOG2N = 6;
    localparam int W     = 11;

    // One complex sample as carried between the FFT and its neighbours.
    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
    } cplx_t;

    // Reverse the LOG2N index bits (FFT output order <-> natural order).
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank N-entry register file for the unloader: one write port,
// one combinational read port, both addressed by {bank, addr}.
module fft_pingpong_ram #(
    parameter int N     = fft_pkg::N,
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int W     = fft_pkg::W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LOG2N:0]   waddr,
    input  logic [2*W-1:0]   wdata,
    input  logic [LOG2N:0]   raddr,
    output logic [2*W-1:0]   rdata
);

    // Contents are deliberately not reset; the full flags gate every read.
    logic [2*W-1:0] mem [2*N];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_unload.sv
// FFT output unloader: captures bit-reversed frames into a ping-pong
// buffer and replays them in natural bin order over valid/ready.
module fft_unload #(
    parameter int N     = fft_pkg::N,
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int W     = fft_pkg::W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [W-1:0]     br_i,
    input  logic [W-1:0]     bi_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [W-1:0]     ar_o,
    output logic [W-1:0]     ai_o,
    output logic [LOG2N-1:0] idx_o,
    output logic             last_o,
    output logic             ovf_o
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    logic [1:0]       full;
    logic             wbank, rbank;
    logic             drop;       // current in-flight frame is being discarded
    logic [LOG2N-1:0] wcnt, rcnt;
    logic [LOG2N-1:0] waddr_rev;
    logic             wstart, wkeep, we, wlast;
    logic             ld, rlast;
    logic [2*W-1:0]   rdata;

    // Input sample k lands at address bitrev(k) so reads run in natural order.
    for (genvar i = 0; i < LOG2N; i++) begin : g_rev
        assign waddr_rev[i] = wcnt[LOG2N-1-i];
    end

    // Accept/drop decided once per frame at its first sample, then held.
    assign wstart = valid_i && (wcnt == '0);
    assign wkeep  = wstart ? !full[wbank] : !drop;
    assign we     = valid_i && wkeep;
    assign wlast  = we && (wcnt == LAST);

    // Output register advances when data is ready and the slot is free.
    assign ld     = full[rbank] && (!valid_o || ready_i);
    assign rlast  = ld && (rcnt == LAST);

    fft_pingpong_ram #(.N(N), .LOG2N(LOG2N), .W(W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr ({wbank, waddr_rev}),
        .wdata ({br_i, bi_i}),
        .raddr ({rbank, rcnt}),
        .rdata (rdata)
    );

    // Write counter, bank select, drop tracking and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt  <= '0;
            wbank <= 1'b0;
            drop  <= 1'b0;
            ovf_o <= 1'b0;
        end else if (valid_i) begin
            wcnt <= wcnt + 1'b1;
            if (wstart) begin
                drop <= full[wbank];
                if (full[wbank]) ovf_o <= 1'b1;
            end
            if (wlast) wbank <= ~wbank;
        end
    end

    // Full flags: set by the writer, cleared by the reader; they never
    // target the same bank in one cycle, since a set needs the bank empty
    // and a clear needs it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            if (wlast) full[wbank] <= 1'b1;
            if (rlast) full[rbank] <= 1'b0;
        end
    end

    // Read counter, bank select and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt    <= '0;
            rbank   <= 1'b0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            ar_o    <= '0;
            ai_o    <= '0;
            idx_o   <= '0;
        end else if (ld) begin
            {ar_o, ai_o} <= rdata;
            idx_o        <= rcnt;
            last_o       <= rlast;
            valid_o      <= 1'b1;
            if (rlast) begin
                rcnt  <= '0;
                rbank <= ~rbank;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end else if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_unload.sv
// Directed bench for fft_unload: single frame, backpressure, gapped input,
// continuous streaming, overflow and mid-operation reset.
module tb_fft_unload;
    import fft_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_i;
    logic [W-1:0]     br_i, bi_i;
    logic             valid_o;
    logic             ready_i;
    logic [W-1:0]     ar_o, ai_o;
    logic [LOG2N-1:0] idx_o;
    logic             last_o;
    logic             ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    fft_unload #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .br_i    (br_i),
        .bi_i    (bi_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .ar_o    (ar_o),
        .ai_o    (ai_o),
        .idx_o   (idx_o),
        .last_o  (last_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    // Accepted-output log plus stall-stability tracking, sampled on negedge.
    logic [W-1:0]     q_ar[$];
    logic [W-1:0]     q_ai[$];
    logic [LOG2N-1:0] q_idx[$];
    logic             q_last[$];
    int               q_cyc[$];
    int               cyc = 0;
    int               stall_err = 0;
    logic             prev_hold = 1'b0;
    logic [2*W+LOG2N+1:0] prev_snap = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold && ({valid_o, last_o, idx_o, ar_o, ai_o} !== prev_snap))
                stall_err++;
            prev_hold = valid_o && !ready_i;
            prev_snap = {valid_o, last_o, idx_o, ar_o, ai_o};
            if (valid_o && ready_i) begin
                q_ar.push_back(ar_o);
                q_ai.push_back(ai_o);
                q_idx.push_back(idx_o);
                q_last.push_back(last_o);
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_log();
        q_ar.delete(); q_ai.delete(); q_idx.delete(); q_last.delete(); q_cyc.delete();
    endtask

    // mode 0: br=bitrev(k), bi=-bitrev(k); mode 1: br=tag*256+k, bi=k
    task automatic drive_sample(input int mode, input int tag, input int k);
        int b;
        @(posedge clk); #1;
        b = int'(bitrev(LOG2N'(k)));
        valid_i = 1'b1;
        if (mode == 0) begin
            br_i = W'(b);
            bi_i = W'(-b);
        end else begin
            br_i = W'(tag * 256 + k);
            bi_i = W'(k);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
        end
    endtask

    // Ends with the last sample driven; caller decides what follows.
    task automatic send_frame(input int mode, input int tag, input int gap);
        for (int k = 0; k < N; k++) begin
            drive_sample(mode, tag, k);
            if (k != N - 1)
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    valid_i = 1'b0;
                end
        end
    endtask

    task automatic wait_outputs(input int n, input int budget, input bit toggle, input string nm);
        int c;
        c = 0;
        while (q_ar.size() < n && c < budget) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
            if (toggle) ready_i = ~ready_i;
            c++;
        end
        chk({nm, "_count"}, q_ar.size(), n);
    endtask

    task automatic check_frame(input int base, input int mode, input int tag, input string nm);
        int b;
        logic [31:0] exp_v, obs_v;
        if (q_ar.size() < base + N) return;
        for (int j = 0; j < N; j++) begin
            b = int'(bitrev(LOG2N'(j)));
            if (mode == 0)
                exp_v = {3'b0, W'(j), W'(-j), LOG2N'(j), (j == N - 1)};
            else
                exp_v = {3'b0, W'(tag * 256 + b), W'(b), LOG2N'(j), (j == N - 1)};
            obs_v = {3'b0, q_ar[base+j], q_ai[base+j], q_idx[base+j], q_last[base+j]};
            chk($sformatf("%s_bin%0d", nm, j), obs_v, exp_v);
        end
    endtask

    initial begin
        int bubbles, bad3;
        rst = 1'b1; valid_i = 1'b0; br_i = '0; bi_i = '0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_data", {ar_o, ai_o, idx_o}, 0);
        rst = 1'b0;

        // Single frame, latency check
        clear_log();
        send_frame(0, 0, 0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("single_valid_before", valid_o, 0);
        @(posedge clk); #1;
        chk("single_valid_rise", valid_o, 1);
        chk("single_idx0", idx_o, 0);
        wait_outputs(N, 200, 1'b0, "single");
        check_frame(0, 0, 0, "single");
        idle(4);
        chk("single_valid_drop", valid_o, 0);

        // Backpressure: ready toggles every cycle while draining
        clear_log();
        stall_err = 0;
        send_frame(0, 0, 0);
        wait_outputs(N, 400, 1'b1, "bp");
        ready_i = 1'b1;
        check_frame(0, 0, 0, "bp");
        chk("bp_stall_stable", stall_err, 0);
        idle(4);

        // Gapped input: valid every third cycle
        clear_log();
        send_frame(0, 0, 2);
        wait_outputs(N, 300, 1'b0, "gap");
        check_frame(0, 0, 0, "gap");
        idle(4);

        // Continuous streaming: 4 back-to-back frames
        clear_log();
        for (int f = 1; f <= 4; f++) send_frame(1, f, 0);
        wait_outputs(4 * N, 500, 1'b0, "stream");
        for (int f = 0; f < 4; f++) check_frame(f * N, 1, f + 1, $sformatf("stream_f%0d", f));
        bubbles = 0;
        for (int i = 1; i < q_cyc.size(); i++)
            if (q_cyc[i] != q_cyc[i-1] + 1) bubbles++;
        chk("stream_bubbles", bubbles, 0);
        chk("stream_ovf", ovf_o, 0);
        idle(4);

        // Overflow: three frames with consumer stalled
        clear_log();
        stall_err = 0;
        ready_i = 1'b0;
        send_frame(1, 1, 0);
        send_frame(1, 2, 0);
        for (int k = 0; k < N; k++) begin
            drive_sample(1, 3, k);
            if (k == 0) chk("ovf_before", ovf_o, 0);
            if (k == 1) chk("ovf_rise", ovf_o, 1);
        end
        idle(2);
        ready_i = 1'b1;
        wait_outputs(2 * N, 400, 1'b0, "ovf");
        idle(80);
        chk("ovf_total", q_ar.size(), 2 * N);
        check_frame(0, 1, 1, "ovf_f1");
        check_frame(N, 1, 2, "ovf_f2");
        bad3 = 0;
        for (int i = 0; i < q_ar.size(); i++)
            if (q_ar[i][W-1:8] == 3'd3) bad3++;
        chk("ovf_no_frame3", bad3, 0);
        chk("ovf_sticky", ovf_o, 1);
        chk("ovf_stall_stable", stall_err, 0);

        // Reset while frame 0 is being read and frame 1 is being written
        clear_log();
        ready_i = 1'b0;
        send_frame(0, 0, 0);
        for (int k = 0; k <= 30; k++) begin
            drive_sample(0, 0, k);
            if (k == 20) ready_i = 1'b1;
        end
        chk("mid_valid_busy", valid_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_last", last_o, 0);
        chk("mid_rst_ovf", ovf_o, 0);
        chk("mid_rst_data", {ar_o, ai_o, idx_o}, 0);
        rst = 1'b0;
        clear_log();
        send_frame(0, 0, 0);
        wait_outputs(N, 200, 1'b0, "post_rst");
        check_frame(0, 0, 0, "post_rst");
        idle(80);
        chk("post_rst_total", q_ar.size(), N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
